e2lp_led_controller: RTL
========================

# e2lp_led_controller

Parametrised LED output controller for the E2LP board. It drives `LED_COUNT` physical LEDs from a host-written pattern and adds three display modes on top of the plain latch: blink, global PWM dimming and rotating scroll. The outputs are fully registered and the input capture is decoupled from the pad registers. It sits between the system bus decode (`Set` as chip enable) and the board LED pads.

## Interface
- `LED_COUNT`, 8: number of LEDs and pattern width (≥2).
- `PWM_BITS`, 4: PWM counter and brightness width (≥1).
- `PRESCALE`, 1024: system clocks per timebase tick (≥2).
- `BLINK_TICKS`, 256: ticks per blink/scroll half-period (≥1).
- `system_clock`  in  1  system clock, all logic on rising edge.
- `system_reset`  in  1  reset; asynchronous and active-high.
- `i_Leds`  in  LED_COUNT  pattern to display.
- `i_Mode`  in  2  display mode: 0 static, 1 blink, 2 PWM dim, 3 scroll.
- `i_Brightness`  in  PWM_BITS  duty setting for mode 2.
- `Set`  in  1  chip enable; captures `i_Leds`, `i_Mode` and `i_Brightness`.
- `LEDS`  out  LED_COUNT  registered pad drive, positive logic.
- `Phase`  out  1  current blink phase, for status readback.

## Operation
- Capture stage: when `Set`=1 on a clock edge, `pattern`, `mode` and `bright` registers load from their inputs. With `Set`=0 they hold.
- Any `Set` also clears the prescaler, the blink counter, `Phase` and the scroll offset. A new write therefore always starts its display sequence from a known point.
- Timebase:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted for one cycle when the prescaler equals PRESCALE-1.
  - The blink counter counts ticks 0..BLINK_TICKS-1. On the tick at which it wraps, `Phase` toggles and the scroll offset advances.
- PWM counter: free-running `PWM_BITS`-bit counter, incremented every clock and wrapping naturally. `pwm_on` = (pwm_cnt < bright).
- Display value `disp`, computed combinationally:
  - mode 0: `pattern`.
  - mode 1: `pattern` when `Phase`=0, all zeros when `Phase`=1.
  - mode 2: `pattern` AND-ed with `pwm_on` replicated to all bits.
  - mode 3: `pattern` rotated left by the scroll offset (bit LED_COUNT-1 wraps into bit 0).
- Scroll offset: counts 0..LED_COUNT-1 and wraps to 0. It advances only in mode 3; in other modes it holds.
- Output stage: `LEDS` <= `disp` every clock, unconditionally.
- Reset: `pattern`, `mode`, `bright`, all counters, `Phase`, the scroll offset and `LEDS` go to 0 immediately, without waiting for a clock edge. Deassertion takes effect at the next clock edge.
- Simultaneous `Set` and `tick`: `Set` wins. Counters clear, `Phase` is 0 and the offset is 0 at the next edge.
- Brightness boundaries:
  - `bright`=0 gives LEDs permanently off.
  - `bright`=2^PWM_BITS-1 gives a duty of (2^PWM_BITS-1)/2^PWM_BITS.
  - Full on is not reachable in mode 2; use mode 0 for full on.

## Timing
- Write latency: `Set` sampled at edge N; `LEDS` shows the new static pattern after edge N+1. This is two register stages (capture, output).
- Mode 1: the first `Phase` toggle occurs PRESCALE·BLINK_TICKS clocks after the `Set` edge. `LEDS` follows it one clock later. The full blink period is 2·PRESCALE·BLINK_TICKS clocks.
- Mode 3: the offset advances every PRESCALE·BLINK_TICKS clocks. The pattern returns to its original position after LED_COUNT advances.
- Mode 2: PWM period is 2^PWM_BITS clocks. `LEDS` lags `pwm_on` by one clock.
- No handshake: `Set` is single-cycle or level. Holding it high keeps reloading the inputs and keeps the timebase cleared, so blink and scroll are frozen at phase 0.

## Test plan
- Reset, then `Set` with `i_Leds`=8'hA5 and mode 0 → `LEDS`=0 through edge N, `LEDS`=8'hA5 after edge N+1, held indefinitely.
- PRESCALE=4, BLINK_TICKS=2, mode 1, pattern 8'hFF → `LEDS` is 8'hFF for 8 clocks, then 8'h00 for 8, repeating. `Phase` mirrors this one clock earlier.
- Mode 2, PWM_BITS=4, bright=4 → exactly 4 of every 16 clocks show `LEDS`=pattern. bright=0 → always 0.
- Mode 3, pattern 8'h81, PRESCALE=4, BLINK_TICKS=1 → `LEDS` steps 81, 03, 06, 0C, 18, 30, 60, C0, 81 every 4 clocks.
- Reset asserted mid-scroll, between clock edges → `LEDS`=0 immediately. After release, `LEDS` stays 0 until the next `Set`.
- `Set` on the same edge as a `tick` in mode 1 → `Phase`=0, counters at 0, and the next toggle occurs a full PRESCALE·BLINK_TICKS clocks later.

Source files
------------

// File: rtl/e2lp_led_controller.sv
// LED pad controller: host-written pattern with static, blink, PWM-dim and scroll modes.
// Capture registers are separate from the pad registers, so a write shows up two edges later.
module e2lp_led_controller #(
   parameter int LED_COUNT   = 8,
   parameter int PWM_BITS    = 4,
   parameter int PRESCALE    = 1024,
   parameter int BLINK_TICKS = 256
) (
   input  logic                 system_clock,
   input  logic                 system_reset,
   input  logic [LED_COUNT-1:0] i_Leds,
   input  logic [1:0]           i_Mode,
   input  logic [PWM_BITS-1:0]  i_Brightness,
   input  logic                 Set,
   output logic [LED_COUNT-1:0] LEDS,
   output logic                 Phase
);

   localparam int PS_W  = $clog2(PRESCALE);
   localparam int BT_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int OFF_W = $clog2(LED_COUNT);

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BLINK_TICKS - 1);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LED_COUNT - 1);

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_PWM    = 2'd2,
      MODE_SCROLL = 2'd3
   } mode_e;

   logic [LED_COUNT-1:0] r_pattern;
   mode_e                r_mode;
   logic [PWM_BITS-1:0]  r_bright;
   logic [PS_W-1:0]      r_presc;
   logic [BT_W-1:0]      r_blink;
   logic [OFF_W-1:0]     r_off;
   logic                 r_phase;
   logic [PWM_BITS-1:0]  r_pwm;
   logic [LED_COUNT-1:0] r_leds;

   logic                   w_tick;
   logic                   w_wrap;
   logic                   w_pwm_on;
   logic [2*LED_COUNT-1:0] w_dbl;
   logic [LED_COUNT-1:0]   w_rot;
   logic [LED_COUNT-1:0]   w_disp;

   assign w_tick   = (r_presc == PS_LAST);
   assign w_wrap   = w_tick && (r_blink == BT_LAST);
   assign w_pwm_on = (r_pwm < r_bright);

   // Rotate-left via a doubled copy: the upper half is the wrapped result.
   assign w_dbl = {r_pattern, r_pattern} << r_off;
   assign w_rot = w_dbl[2*LED_COUNT-1:LED_COUNT];

   // Capture stage
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         r_pattern <= '0;
         r_mode    <= MODE_STATIC;
         r_bright  <= '0;
      end else if (Set) begin
         r_pattern <= i_Leds;
         r_mode    <= mode_e'(i_Mode);
         r_bright  <= i_Brightness;
      end
   end

   // Timebase: a write restarts the display sequence and beats a coincident tick.
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         r_presc <= '0;
         r_blink <= '0;
         r_phase <= 1'b0;
         r_off   <= '0;
      end else if (Set) begin
         r_presc <= '0;
         r_blink <= '0;
         r_phase <= 1'b0;
         r_off   <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick)
            r_blink <= (r_blink == BT_LAST) ? '0 : r_blink + 1'b1;
         if (w_wrap) begin
            r_phase <= ~r_phase;
            if (r_mode == MODE_SCROLL)
               r_off <= (r_off == OFF_LAST) ? '0 : r_off + 1'b1;
         end
      end
   end

   // PWM counter free-runs and is not restarted by writes.
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) r_pwm <= '0;
      else              r_pwm <= r_pwm + 1'b1;
   end

   always_comb begin
      w_disp = r_pattern;
      unique case (r_mode)
         MODE_STATIC: w_disp = r_pattern;
         MODE_BLINK:  w_disp = r_phase ? '0 : r_pattern;
         MODE_PWM:    w_disp = r_pattern & {LED_COUNT{w_pwm_on}};
         MODE_SCROLL: w_disp = w_rot;
         default:     w_disp = r_pattern;
      endcase
   end

   // Output stage
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) r_leds <= '0;
      else              r_leds <= w_disp;
   end

   assign LEDS  = r_leds;
   assign Phase = r_phase;

endmodule
